// File: rtl/spi_frame_sequencer_if.sv
// Bus bundle between the CPU-side producer, the sequencer and the SPI_TX core.
interface spi_frame_sequencer_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             en;
  logic             flush;
  logic             push_valid;
  logic             push_ready;
  logic [9:0]       push_data;
  logic [LVL_W-1:0] fifo_level;
  logic             busy;
  logic             frame_done;
  logic             spi_wrt;
  logic [15:0]      spi_tx_data;
  logic             spi_done;
  logic             spi_cs_n;
  logic             spi_dc;

  // Environment side: producer controls plus the core's done level.
  modport master (
    output en, flush, push_valid, push_data, spi_done,
    input  push_ready, fifo_level, busy, frame_done,
    input  spi_wrt, spi_tx_data, spi_cs_n, spi_dc
  );

  // Sequencer side.
  modport slave (
    input  en, flush, push_valid, push_data, spi_done,
    output push_ready, fifo_level, busy, frame_done,
    output spi_wrt, spi_tx_data, spi_cs_n, spi_dc
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// SPI frame sequencer: queues {last,dc,byte} descriptors and streams them to
// the SPI_TX core inside one chip-select window per frame.
module spi_frame_sequencer #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  spi_frame_sequencer_if.slave bus
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_HOLD
  } state_e;

  // Descriptor storage and pointers.
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ready_q;

  // Sequencer state and registered outputs.
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             wrt_q;
  logic [15:0]      tx_data_q;
  logic             cs_n_q;
  logic             dc_q;

  logic [9:0]       head_c;
  logic             pop_c;
  logic             push_c;
  logic             empty_c;
  logic             full_c;

  assign head_c  = mem_q[rd_ptr_q];
  assign empty_c = (level_q == '0);
  assign full_c  = (level_q == LVL_FULL);

  // A pop only happens from ISSUE when the core is idle; flush suppresses it.
  assign pop_c  = (state_q == S_ISSUE) && !empty_c && bus.spi_done && !bus.flush;

  // A push is taken when not full, or when full but a pop frees a slot this cycle.
  assign push_c = bus.push_valid && (!full_c || pop_c) && !bus.flush;

  // FIFO pointer and level next-state; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      push_ready_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      push_ready_q <= (level_d != LVL_FULL);
    end
  end

  // Descriptor storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= bus.push_data;
    end
  end

  // Frame sequencer with registered SPI-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wrt_q        <= 1'b0;
      tx_data_q    <= 16'h0000;
      cs_n_q       <= 1'b1;
      dc_q         <= 1'b1;
    end else begin
      wrt_q        <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A flush in the same cycle empties the queue, so do not open a frame.
          if (bus.en && !empty_c && bus.spi_done && !bus.flush) begin
            state_q <= S_SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            last_q  <= 1'b0;
            cnt_q   <= SETUP_LOAD;
          end
        end
        S_SETUP: begin
          if (bus.flush) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LOAD;
          end else if (cnt_q == '0) begin
            state_q <= S_ISSUE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_ISSUE: begin
          // Empty queue with no last byte seen: hold CS low and wait for data.
          if (bus.flush) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LOAD;
          end else if (pop_c) begin
            wrt_q     <= 1'b1;
            tx_data_q <= {head_c[7:0], 8'h00};
            dc_q      <= head_c[8];
            last_q    <= head_c[9];
            state_q   <= S_ARM;
          end
        end
        S_ARM: begin
          // Core still shows done this cycle; skip it.
          if (bus.flush) begin
            last_q <= 1'b1;
          end
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.flush) begin
            last_q <= 1'b1;
          end
          if (bus.spi_done) begin
            if (last_q || bus.flush) begin
              state_q <= S_HOLD;
              cnt_q   <= HOLD_LOAD;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q       <= 1'b1;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.push_ready  = push_ready_q;
  assign bus.fifo_level  = level_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.spi_wrt     = wrt_q;
  assign bus.spi_tx_data = tx_data_q;
  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_dc      = dc_q;

endmodule
